buff16_fifo: RTL and testbench
==============================

// Module: buff16_fifo
// PURPOSE
//  Registered, flow-controlled 16-bit word buffer. It is the clocked counterpart of the
//  combinational 16-bit pass-through buffer.
//  Absorbs words from a producer (CPU datapath/memory side) and hands them to a consumer
//  one clock later, with valid/ready backpressure on both ends.
//  First-word-fall-through: the head word is presented on out_data whenever out_valid=1.
// PARAMETERS
//  WIDTH    16   data word width in bits
//  DEPTH    4    number of storage entries; must be a power of two, >=2
//  CNT_W    3    count width = log2(DEPTH)+1
// PORTS
//  CLK        in   1        single clock; all state updates on rising edge
//  Reset      in   1        asynchronous, active-high reset
//  in_data    in   WIDTH    word from producer
//  in_valid   in   1        producer offers in_data this cycle
//  in_ready   out  1        buffer accepts a word this cycle (push when in_valid&in_ready)
//  out_data   out  WIDTH    head word to consumer
//  out_valid  out  1        head word present (pop when out_valid&out_ready)
//  out_ready  in   1        consumer takes out_data this cycle
//  count      out  CNT_W    number of words currently stored, 0..DEPTH
// BEHAVIOUR
//  - One clock (CLK); reset is asynchronous and active-high (Reset).
//  - While Reset=1: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, in_ready=0.
//    Storage contents are not reset.
//  - After Reset deasserts: in_ready=1 from the first cycle.
//  - in_ready  = (count != DEPTH) & ~Reset.  out_valid = (count != 0).
//  - Push: on edge with in_valid&in_ready, mem[wr_ptr]<=in_data and wr_ptr<=wr_ptr+1.
//  - Pop: on edge with out_valid&out_ready, rd_ptr<=rd_ptr+1.
//  - Count update:
//    - push only: count+1.
//    - pop only: count-1.
//    - push and pop together: count unchanged, both pointers advance.
//  - Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N.
//    No combinational in->out path.
//  - out_data = mem[rd_ptr] when count!=0, else 0.
//  - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. No bubble at wrap.
//  - Full (count=DEPTH): in_ready=0, so in_valid is ignored, even if a pop occurs in the
//    same cycle (no full-pass-through). in_ready rises the cycle after the pop.
//  - Empty (count=0): out_ready is ignored and the pointers and count hold.
//  - Producer must hold in_data/in_valid stable until accepted. Buffer holds out_data
//    stable while out_valid=1 and out_ready=0.
//  - Reset asserted mid-transfer: all stored words are discarded immediately
//    (asynchronous), and out_valid drops in the same cycle.
//  - No overflow/underflow is possible through the handshake. count never exceeds DEPTH.
// STRUCTURE
//  - Shared header (defines): BUFF_WIDTH=16, BUFF_DEPTH=4, and the derived count width.
//    These are shared with the other 16-bit datapath blocks.
//  - One sub-module: buff16_regfile, a DEPTH x WIDTH register array with one synchronous
//    write port (we, waddr, wdata) and one asynchronous read port (raddr -> rdata).
//    It has no reset.
//  - Top-level logic: pointers, count, handshake decode, out_data zero-mux.
// TESTING
//  1 Reset: assert Reset mid-run with count=3 -> count=0, out_valid=0, out_data=16'h0000,
//    in_ready=0 in the same cycle; in_ready=1 the first cycle after release.
//  2 Single word: push 16'hBEEF with out_ready=0 -> next cycle out_valid=1,
//    out_data=16'hBEEF, count=1; it stays stable for 5 stalled cycles; pop -> count=0.
//  3 Fill and overflow attempt: push 16'h0001..0004 -> count=4, in_ready=0.
//    Offer 16'h0005 for 3 cycles -> not stored; drain yields 0001,0002,0003,0004 in order.
//  4 Wrap-around: push and pop 10 words 16'hA000..A009 with random out_ready
//    -> output order preserved across 2 pointer wraps; count never >4, never <0.
//  5 Simultaneous push and pop at count=2 -> count stays 2, both pointers advance.
//    At count=4 with pop plus in_valid -> count=3, and the incoming word is not taken.
//  6 Empty pop: out_ready=1, in_valid=0 for 4 cycles at count=0 -> count=0, out_valid=0,
//    and the pointers are unchanged.

Source files
------------

// File: rtl/buff16_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// buff16_pkg : shared sizing for the 16-bit datapath blocks
// Rev 1.0
// ============================================================================
package buff16_pkg;

  localparam int BUFF_WIDTH = 16;
  localparam int BUFF_DEPTH = 4;
  localparam int BUFF_CNT_W = $clog2(BUFF_DEPTH) + 1;

  // Handshake outcome of one cycle, encoded as {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } xfer_op_e;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage : buff16_pkg
`default_nettype wire

// File: rtl/buff16_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// buff16_regfile : DEPTH x WIDTH array, one sync write port, one async read port
// Rev 1.0
// ============================================================================
module buff16_regfile
  import buff16_pkg::*;
#(
  parameter int WIDTH = BUFF_WIDTH,
  parameter int DEPTH = BUFF_DEPTH,
  parameter int AW    = $clog2(BUFF_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Deliberately no reset: the owner tracks validity through its count
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : buff16_regfile
`default_nettype wire

// File: rtl/buff16_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// buff16_fifo : registered first-word-fall-through word buffer, valid/ready
// Rev 1.0
// ============================================================================
module buff16_fifo
  import buff16_pkg::*;
#(
  parameter int WIDTH = BUFF_WIDTH,
  parameter int DEPTH = BUFF_DEPTH,
  parameter int CNT_W = BUFF_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2 || CNT_W != PTR_W + 1) begin : g_bad_params
      $error("buff16_fifo: DEPTH must be a power of two >= 2 and CNT_W = log2(DEPTH)+1");
    end
  endgenerate

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] rd_word;
  logic             push;
  logic             pop;
  xfer_op_e         op;

  // Full blocks pushes even when a pop happens in the same cycle
  assign in_ready  = (count != FULL_CNT) & ~Reset;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    op = xfer_op_e'({push, pop});
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  buff16_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_regfile (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Stale storage is never exposed while the buffer is empty
  assign out_data = out_valid ? rd_word : '0;

endmodule : buff16_fifo
`default_nettype wire

// File: tb/tb_buff16_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_buff16_fifo : directed vector table plus hand-written corner sequences
// Rev 1.0
// ============================================================================
module tb_buff16_fifo;

  logic        CLK;
  logic        Reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic [2:0]  c;
    logic        ov;
    logic [15:0] od;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  buff16_fifo #(.WIDTH(16), .DEPTH(4), .CNT_W(3)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic ordy,
                              input logic [2:0] c, input logic ov, input logic [15:0] od,
                              input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.c = c; v.ov = ov; v.od = od; v.ir = ir;
    return v;
  endfunction

  task automatic step(input logic iv, input logic [15:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [2:0] c, input logic ov,
                           input logic [15:0] od, input logic ir);
    chk({nm, ".count"},     32'(count),     32'(c));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".out_data"},  32'(out_data),  32'(od));
    chk({nm, ".in_ready"},  32'(in_ready),  32'(ir));
  endtask

  logic [15:0] q[$];
  int          sent;
  int          got;
  int          mcount;
  logic        do_push;
  logic        do_pop;

  initial begin
    // single word, stall, pop
    vecs.push_back(mk(1, 16'hBEEF, 0, 3'd1, 1, 16'hBEEF, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 16'h0000, 0, 3'd1, 1, 16'hBEEF, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd0, 0, 16'h0000, 1));
    // fill, overflow attempt, drain
    vecs.push_back(mk(1, 16'h0001, 0, 3'd1, 1, 16'h0001, 1));
    vecs.push_back(mk(1, 16'h0002, 0, 3'd2, 1, 16'h0001, 1));
    vecs.push_back(mk(1, 16'h0003, 0, 3'd3, 1, 16'h0001, 1));
    vecs.push_back(mk(1, 16'h0004, 0, 3'd4, 1, 16'h0001, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 16'h0005, 0, 3'd4, 1, 16'h0001, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd3, 1, 16'h0002, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd2, 1, 16'h0003, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd1, 1, 16'h0004, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd0, 0, 16'h0000, 1));
    // simultaneous push/pop at count=2, then pop+offer while full
    vecs.push_back(mk(1, 16'h1111, 0, 3'd1, 1, 16'h1111, 1));
    vecs.push_back(mk(1, 16'h2222, 0, 3'd2, 1, 16'h1111, 1));
    vecs.push_back(mk(1, 16'h3333, 1, 3'd2, 1, 16'h2222, 1));
    vecs.push_back(mk(1, 16'h4444, 1, 3'd2, 1, 16'h3333, 1));
    vecs.push_back(mk(1, 16'h5555, 0, 3'd3, 1, 16'h3333, 1));
    vecs.push_back(mk(1, 16'h6666, 0, 3'd4, 1, 16'h3333, 0));
    vecs.push_back(mk(1, 16'h7777, 1, 3'd3, 1, 16'h4444, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd2, 1, 16'h5555, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd1, 1, 16'h6666, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd0, 0, 16'h0000, 1));

    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_state("reset_hold", 3'd0, 0, 16'h0000, 0);
    Reset = 1'b0;
    #1;
    chk("reset_release.in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk_state($sformatf("vec%0d", i), vecs[i].c, vecs[i].ov, vecs[i].od, vecs[i].ir);
    end

    // empty pop: pointers must hold, proven by the next word landing at the head
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0000, 1);
      chk_state($sformatf("empty_pop%0d", i), 3'd0, 0, 16'h0000, 1);
    end
    step(1, 16'hABCD, 0);
    chk_state("after_empty_push", 3'd1, 1, 16'hABCD, 1);
    step(0, 16'h0000, 1);
    chk_state("after_empty_pop", 3'd0, 0, 16'h0000, 1);

    // asynchronous reset mid-run with three words stored
    step(1, 16'hC001, 0);
    step(1, 16'hC002, 0);
    step(1, 16'hC003, 0);
    chk_state("pre_reset", 3'd3, 1, 16'hC001, 1);
    in_valid = 1'b0;
    Reset    = 1'b1;
    #1;
    chk_state("async_reset", 3'd0, 0, 16'h0000, 0);
    @(posedge CLK);
    #1;
    chk_state("reset_held", 3'd0, 0, 16'h0000, 0);
    Reset = 1'b0;
    #1;
    chk_state("reset_released", 3'd0, 0, 16'h0000, 1);
    step(0, 16'h0000, 0);
    chk_state("discarded", 3'd0, 0, 16'h0000, 1);

    // wrap-around with random consumer stalls, checked against a queue model
    sent   = 0;
    got    = 0;
    mcount = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      in_valid  = (sent < 10);
      in_data   = 16'hA000 + 16'(sent);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("wrap.out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("wrap.in_ready",  32'(in_ready),  32'(mcount != 4));
      if (mcount != 0) chk("wrap.out_data", 32'(out_data), 32'(q[0]));
      do_push = in_valid && (mcount != 4);
      do_pop  = out_ready && (mcount != 0);
      @(posedge CLK);
      #1;
      if (do_pop) begin
        void'(q.pop_front());
        got++;
        mcount--;
      end
      if (do_push) begin
        q.push_back(16'hA000 + 16'(sent));
        sent++;
        mcount++;
      end
      chk("wrap.count", 32'(count), 32'(mcount));
    end
    chk("wrap.words_received", 32'(got), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_buff16_fifo
`default_nettype wire
